// File: rtl/serial_master_arbiter.sv
// rtl/serial_master_arbiter.sv - round-robin arbiter sharing one serial master engine among N_REQ requesters
module serial_master_arbiter #(
  parameter int N_REQ   = 3,
  parameter int DW      = 8,
  parameter int TIMEOUT = 4095
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ*DW-1:0] i_wdata,
  output logic [N_REQ-1:0]    o_gnt,
  output logic [N_REQ-1:0]    o_done,
  output logic [DW-1:0]       o_rdata,
  output logic                o_err,
  output logic                o_start,
  output logic [DW-1:0]       o_tx_data,
  input  logic                i_busy,
  input  logic                i_done,
  input  logic [DW-1:0]       i_rx_data
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               start_q, start_d;
  logic [DW-1:0]      tx_q, tx_d;

  logic               hi_found;
  logic [IW-1:0]      hi_idx, lo_idx, pick;
  logic [N_REQ-1:0]   sel_gnt;
  logic [DW-1:0]      sel_data;

  // Requesters above the pointer win over those at or below it; lowest index first within each half.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    sel_gnt  = '0;
    sel_data = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        if (i > int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end else begin
          lo_idx = IW'(i);
        end
      end
    end
    pick = hi_found ? hi_idx : lo_idx;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == pick) begin
        sel_gnt[i] = 1'b1;
        sel_data   = i_wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    rdata_d = rdata_q;
    err_d   = err_q;
    start_d = 1'b0;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          gnt_d   = sel_gnt;
          tx_d    = sel_data;
          win_d   = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!i_busy) begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_done) begin
          rdata_d = i_rx_data;
          err_d   = 1'b0;
          done_d  = gnt_q;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          done_d  = gnt_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        ptr_d   = win_q;
        gnt_d   = '0;
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      start_q <= start_d;
      tx_q    <= tx_d;
    end
  end

  assign o_gnt     = gnt_q;
  assign o_done    = done_q;
  assign o_rdata   = rdata_q;
  assign o_err     = err_q;
  assign o_start   = start_q;
  assign o_tx_data = tx_q;

endmodule

// File: tb/tb_serial_master_arbiter.sv
// tb/tb_serial_master_arbiter.sv - directed self-checking bench for serial_master_arbiter
module tb_serial_master_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [23:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic [7:0]  rdata;
  logic        err;
  logic        start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        eng_done;
  logic [7:0]  rx_data;

  int checks   = 0;
  int errors   = 0;
  int n_starts = 0;

  serial_master_arbiter #(.N_REQ(3), .DW(8), .TIMEOUT(16)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_wdata   (wdata),
    .o_gnt     (gnt),
    .o_done    (done),
    .o_rdata   (rdata),
    .o_err     (err),
    .o_start   (start),
    .o_tx_data (tx_data),
    .i_busy    (busy),
    .i_done    (eng_done),
    .i_rx_data (rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (start) n_starts++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Engine side: wait for the start pulse, answer dly cycles later, then verify completion and idle gap.
  task automatic serve(input string tag, input logic [2:0] g, input int dly, input logic [7:0] rx);
    int n;
    int s0;
    n  = 0;
    s0 = n_starts - (start ? 1 : 0);
    while (!start && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_start"}, 32'(start), 32'h1);
    repeat (dly) tick();
    rx_data  = rx;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check({tag, "_done"}, 32'(done), 32'(g));
    check({tag, "_rdata"}, 32'(rdata), 32'(rx));
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_gnt_held"}, 32'(gnt), 32'(g));
    tick();
    check({tag, "_done_clr"}, 32'(done), 32'h0);
    check({tag, "_idle_gap"}, 32'(gnt), 32'h0);
    check({tag, "_one_start"}, 32'(n_starts - s0), 32'h1);
  endtask

  task automatic txn(input string tag, input logic [2:0] g, input logic [7:0] tx,
                     input int dly, input logic [7:0] rx);
    tick();
    check({tag, "_gnt"}, 32'(gnt), 32'(g));
    check({tag, "_tx"}, 32'(tx_data), 32'(tx));
    serve(tag, g, dly, rx);
  endtask

  logic [2:0] ord_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [7:0] ord_t [6] = '{8'hA0, 8'hB1, 8'hC2, 8'hA0, 8'hB1, 8'hC2};
  logic [2:0] fair_g [4] = '{3'b001, 3'b100, 3'b001, 3'b100};
  logic [7:0] fair_t [4] = '{8'hA0, 8'hC2, 8'hA0, 8'hC2};

  initial begin
    int n;
    rst_n    = 1'b0;
    req      = '0;
    wdata    = '0;
    busy     = 1'b0;
    eng_done = 1'b0;
    rx_data  = '0;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_start", 32'(start), 32'h0);
    check("rst_tx", 32'(tx_data), 32'h0);
    rst_n = 1'b1;

    wdata = 24'h0000A5;
    req   = 3'b001;
    txn("single", 3'b001, 8'hA5, 10, 8'h3C);
    req = 3'b000;

    do_reset();
    wdata = {8'hC2, 8'hB1, 8'hA0};
    req   = 3'b111;
    for (int k = 0; k < 6; k++)
      txn($sformatf("rr%0d", k), ord_g[k], ord_t[k], 2 + k, 8'h10 + 8'(k));

    req = 3'b101;
    for (int k = 0; k < 4; k++)
      txn($sformatf("fair%0d", k), fair_g[k], fair_t[k], 1 + k, 8'h20 + 8'(k));
    req = 3'b000;

    wdata = {8'hC2, 8'h5E, 8'hA0};
    busy  = 1'b1;
    req   = 3'b010;
    tick();
    check("busy_gnt", 32'(gnt), 32'h2);
    check("busy_tx", 32'(tx_data), 32'h5E);
    wdata = {8'hC2, 8'h77, 8'hA0};
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("busy_nostart%0d", k), 32'(start), 32'h0);
      check($sformatf("busy_txhold%0d", k), 32'(tx_data), 32'h5E);
    end
    busy = 1'b0;
    tick();
    check("busy_start", 32'(start), 32'h1);
    check("busy_tx_start", 32'(tx_data), 32'h5E);
    serve("busy", 3'b010, 3, 8'h99);
    req = 3'b000;

    wdata = {8'hC2, 8'hB1, 8'hA0};
    req   = 3'b001;
    tick();
    check("to_gnt", 32'(gnt), 32'h1);
    tick();
    check("to_start", 32'(start), 32'h1);
    n = 0;
    while (done == 3'b000 && n < 40) begin
      tick();
      n++;
    end
    check("to_latency", 32'(n), 32'd16);
    check("to_done", 32'(done), 32'h1);
    check("to_err", 32'(err), 32'h1);
    check("to_rdata", 32'(rdata), 32'h0);
    req = 3'b000;
    tick();
    check("to_done_clr", 32'(done), 32'h0);
    check("to_err_clr", 32'(err), 32'h0);
    rx_data  = 8'hFF;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("late_done%0d", k), 32'(done), 32'h0);
      check($sformatf("late_err%0d", k), 32'(err), 32'h0);
      check($sformatf("late_rdata%0d", k), 32'(rdata), 32'h0);
      check($sformatf("late_gnt%0d", k), 32'(gnt), 32'h0);
    end

    req = 3'b001;
    tick();
    check("rw_gnt", 32'(gnt), 32'h1);
    tick();
    check("rw_start", 32'(start), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rw_gnt_clr", 32'(gnt), 32'h0);
    check("rw_start_clr", 32'(start), 32'h0);
    check("rw_tx_clr", 32'(tx_data), 32'h0);
    check("rw_done_clr", 32'(done), 32'h0);
    check("rw_err_clr", 32'(err), 32'h0);
    check("rw_rdata_clr", 32'(rdata), 32'h0);
    req = 3'b110;
    tick();
    tick();
    rst_n = 1'b1;
    txn("rw_after", 3'b010, 8'hB1, 4, 8'h42);
    req = 3'b000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
